// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit: forwarding select codes,
// the zero register and the shadow-slot records tracked per pipeline stage.
package hazard_pkg;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wreg;
        logic       wen;
        logic       load;
    } slot_t;

    // Later stages only need to know what they will write back.
    typedef struct packed {
        logic [4:0] wreg;
        logic       wen;
        logic       load;
    } wslot_t;

    // A load still in MEM has no data yet, so only non-load MEM writers forward.
    function automatic logic [1:0] fwd_select(input logic [4:0] src,
                                              input wslot_t     mem,
                                              input wslot_t     wb);
        logic [1:0] sel;
        sel = FWD_RF;
        if (mem.wen && mem.wreg != REG_ZERO && mem.wreg == src && !mem.load)
            sel = FWD_MEM;
        else if (wb.wen && wb.wreg != REG_ZERO && wb.wreg == src)
            sel = FWD_WB;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_if.sv
// Bundle between the ID-stage control and the hazard unit: ID instruction
// fields and squash in, stall/forwarding decisions and stall count out.
interface hazard_if;

    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic [4:0]  id_wreg;
    logic        id_wen;
    logic        id_load;
    logic        flush;
    logic        stall;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic [31:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_wen, id_load, flush,
        input  stall, fwd_a_sel, fwd_b_sel, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_wen, id_load, flush,
        output stall, fwd_a_sel, fwd_b_sel, stall_cnt
    );

endinterface

// File: rtl/hazard_slot.sv
// One pipeline shadow slot: async-reset register that loads a bubble (all
// zeros) instead of its input when bubble is high.
module hazard_slot #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (bubble)
            q <= '0;
        else
            q <= d;
    end

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall detection and EX operand forwarding for a 5-stage pipeline.
// Optional stall counter is enabled by defining HAZARD_STALL_CNT_EN.
module hazard_unit
    import hazard_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    hazard_if.slave  bus
);

    slot_t  id_slot;
    slot_t  ex_q;
    wslot_t ex_w;
    wslot_t mem_q;
    wslot_t wb_q;
    logic   stall;
    logic   ex_bubble;

    always_comb begin
        id_slot      = '0;
        id_slot.rs   = bus.id_rs;
        id_slot.rt   = bus.id_rt;
        id_slot.wreg = bus.id_wreg;
        id_slot.wen  = bus.id_wen;
        id_slot.load = bus.id_load;
    end

    always_comb begin
        ex_w      = '0;
        ex_w.wreg = ex_q.wreg;
        ex_w.wen  = ex_q.wen;
        ex_w.load = ex_q.load;
    end

    // A load in EX cannot supply its data to the very next instruction.
    always_comb begin
        stall = 1'b0;
        if (ex_q.load && ex_q.wen && ex_q.wreg != REG_ZERO) begin
            if ((bus.id_use_rs && bus.id_rs == ex_q.wreg) ||
                (bus.id_use_rt && bus.id_rt == ex_q.wreg))
                stall = 1'b1;
        end
    end

    assign ex_bubble     = stall | bus.flush;
    assign bus.stall     = stall;
    assign bus.fwd_a_sel = fwd_select(ex_q.rs, mem_q, wb_q);
    assign bus.fwd_b_sel = fwd_select(ex_q.rt, mem_q, wb_q);

    hazard_slot #(.W($bits(slot_t))) u_ex (
        .clk    (clk),
        .rst_n  (rst_n),
        .bubble (ex_bubble),
        .d      (id_slot),
        .q      (ex_q)
    );

    hazard_slot #(.W($bits(wslot_t))) u_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .bubble (1'b0),
        .d      (ex_w),
        .q      (mem_q)
    );

    hazard_slot #(.W($bits(wslot_t))) u_wb (
        .clk    (clk),
        .rst_n  (rst_n),
        .bubble (1'b0),
        .d      (mem_q),
        .q      (wb_q)
    );

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_q <= '0;
        else if (stall && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed test of hazard_unit: forwarding, load-use stall, register zero,
// flush, and reset in the middle of a stall.
module tb_hazard_unit;

`ifdef HAZARD_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    hazard_if bus ();

    hazard_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one ID instruction on the falling edge, then settle before sampling.
    task automatic apply_stimulus(input logic [4:0] rs, input logic [4:0] rt,
                                  input logic use_rs, input logic use_rt,
                                  input logic [4:0] wreg, input logic wen,
                                  input logic load, input logic fl);
        @(negedge clk);
        bus.id_rs     = rs;
        bus.id_rt     = rt;
        bus.id_use_rs = use_rs;
        bus.id_use_rt = use_rt;
        bus.id_wreg   = wreg;
        bus.id_wen    = wen;
        bus.id_load   = load;
        bus.flush     = fl;
        #1;
    endtask

    task automatic nop();
        apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.id_rs = '0; bus.id_rt = '0; bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0;
        bus.id_wreg = '0; bus.id_wen = 1'b0; bus.id_load = 1'b0; bus.flush = 1'b0;
        #3;
        check_output("reset_stall", {31'd0, bus.stall}, 32'd0);
        check_output("reset_fwd_a", {30'd0, bus.fwd_a_sel}, 32'd0);
        check_output("reset_fwd_b", {30'd0, bus.fwd_b_sel}, 32'd0);
        check_output("reset_cnt", bus.stall_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // add $3 ; sub $6,$3,$4 ; or $8,$3 ; nop
        apply_stimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        apply_stimulus(5'd3, 5'd4, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        check_output("alu_no_stall", {31'd0, bus.stall}, 32'd0);
        apply_stimulus(5'd3, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        check_output("fwd_mem_a", {30'd0, bus.fwd_a_sel}, 32'd1);
        check_output("fwd_mem_b_none", {30'd0, bus.fwd_b_sel}, 32'd0);
        nop();
        check_output("fwd_wb_a", {30'd0, bus.fwd_a_sel}, 32'd2);
        check_output("fwd_wb_b_none", {30'd0, bus.fwd_b_sel}, 32'd0);

        // lw $5 ; add $9,$2,$5 -> one-cycle stall then WB forward on rt
        apply_stimulus(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        check_output("lw_issue_no_stall", {31'd0, bus.stall}, 32'd0);
        apply_stimulus(5'd2, 5'd5, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        check_output("load_use_stall", {31'd0, bus.stall}, 32'd1);
        apply_stimulus(5'd2, 5'd5, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        check_output("stall_one_cycle", {31'd0, bus.stall}, 32'd0);
        check_output("bubble_fwd_a", {30'd0, bus.fwd_a_sel}, 32'd0);
        check_output("bubble_fwd_b", {30'd0, bus.fwd_b_sel}, 32'd0);
        nop();
        check_output("load_fwd_b_wb", {30'd0, bus.fwd_b_sel}, 32'd2);
        check_output("load_fwd_a_none", {30'd0, bus.fwd_a_sel}, 32'd0);
        check_output("after_load_no_stall", {31'd0, bus.stall}, 32'd0);

        // Two writers of $0 ahead of a reader of $0
        apply_stimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(5'd0, 5'd0, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
        nop();
        check_output("r0_fwd_a", {30'd0, bus.fwd_a_sel}, 32'd0);
        check_output("r0_fwd_b", {30'd0, bus.fwd_b_sel}, 32'd0);
        apply_stimulus(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        apply_stimulus(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        check_output("r0_load_no_stall", {31'd0, bus.stall}, 32'd0);

        // $7 written in both MEM and WB: MEM wins
        apply_stimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        apply_stimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        apply_stimulus(5'd7, 5'd7, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
        nop();
        check_output("prio_mem_a", {30'd0, bus.fwd_a_sel}, 32'd1);
        check_output("prio_mem_b", {30'd0, bus.fwd_b_sel}, 32'd1);

        // Flushed add $4 must not become a forwarding source
        apply_stimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1);
        apply_stimulus(5'd4, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_output("flush_no_stall", {31'd0, bus.stall}, 32'd0);
        check_output("flush_ex_bubble", {30'd0, bus.fwd_a_sel}, 32'd0);
        nop();
        check_output("flush_no_fwd", {30'd0, bus.fwd_a_sel}, 32'd0);

        // Stall and flush together
        apply_stimulus(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        apply_stimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0, 1'b1);
        check_output("stall_with_flush", {31'd0, bus.stall}, 32'd1);
        nop();
        check_output("stall_flush_released", {31'd0, bus.stall}, 32'd0);

        // Reset asserted while a load-use stall is pending
        apply_stimulus(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        apply_stimulus(5'd0, 5'd5, 1'b0, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0);
        check_output("pre_reset_stall", {31'd0, bus.stall}, 32'd1);
        check_output("pre_reset_cnt", bus.stall_cnt, CNT_EN ? 32'd2 : 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check_output("mid_reset_stall", {31'd0, bus.stall}, 32'd0);
        check_output("mid_reset_fwd_a", {30'd0, bus.fwd_a_sel}, 32'd0);
        check_output("mid_reset_fwd_b", {30'd0, bus.fwd_b_sel}, 32'd0);
        check_output("mid_reset_cnt", bus.stall_cnt, 32'd0);

        // Three load-use stalls after release; first edge loads EX from ID
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
            if (i == 0) rst_n = 1'b1;
            check_output("reuse_lw_no_stall", {31'd0, bus.stall}, 32'd0);
            apply_stimulus(5'd0, 5'd5, 1'b0, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0);
            check_output("reuse_stall", {31'd0, bus.stall}, 32'd1);
        end
        nop();
        check_output("final_cnt", bus.stall_cnt, CNT_EN ? 32'd3 : 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk, rst_n.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 id_rs, id_rt  input  5 each  source register numbers of the instruction in ID.
REQ-005 id_use_rs, id_use_rt  input  1 each  ID instruction reads rs/rt in EX.
REQ-006 id_wreg  input  5  destination register of the ID instruction; id_wen input 1 writes a register; id_load input 1 is a load.
REQ-007 flush  input  1  squash the ID instruction (taken branch/jump) instead of advancing it to EX.
REQ-008 stall  output  1  freeze PC and IF/ID, insert bubble into EX.
REQ-009 fwd_a_sel, fwd_b_sel  output  2 each  EX operand mux selects: 00 register file, 01 MEM result, 10 WB result; 11 never driven.
REQ-010 stall_cnt  output  32  count of stall cycles (see Configuration).

Function
REQ-011 SHALL hold three shadow slots, EX, MEM and WB, each {rs, rt, wreg, wen, load}; MEM and WB keep only {wreg, wen, load}.
REQ-012 Each edge: WB<=MEM, MEM<=EX unconditionally.
REQ-013 Each edge: EX<=ID fields when stall=0 and flush=0; otherwise EX<=bubble (wen=0, load=0, rs=rt=wreg=0).
REQ-014 stall SHALL be combinational: EX.load & EX.wen & EX.wreg!=0 & ((id_use_rs & id_rs==EX.wreg) | (id_use_rt & id_rt==EX.wreg)).
REQ-015 Load-use stall SHALL last exactly one cycle; the following cycle forwards from MEM or WB.
REQ-016 fwd_a_sel SHALL be combinational from EX.rs: 01 if MEM.wen & MEM.wreg!=0 & MEM.wreg==EX.rs & !MEM.load; else 10 if WB.wen & WB.wreg!=0 & WB.wreg==EX.rs; else 00. fwd_b_sel identical on EX.rt.
REQ-017 MEM match on a load SHALL NOT forward (data not ready); REQ-014 guarantees this case cannot occur for a used operand.
REQ-018 MEM has priority over WB when both match (youngest value wins).
REQ-019 Register 0 SHALL never cause forwarding or stall.
REQ-020 stall and flush asserted together: bubble enters EX, stall still output high.

Reset
REQ-021 rst_n low SHALL immediately clear all slots to bubble, driving stall=0, fwd_a_sel=fwd_b_sel=00, stall_cnt=0.
REQ-022 Reset deasserted mid-stream: first edge after release loads EX from ID per REQ-013; no stale forwarding.

Configuration
REQ-023 With HAZARD_STALL_CNT_EN defined: stall_cnt increments by 1 on every edge where stall=1, saturating at 32'hFFFFFFFF.
REQ-024 Without HAZARD_STALL_CNT_EN: no counter register; stall_cnt tied to 0; all other behaviour identical.

Structure
REQ-025 Shared package hazard_pkg SHALL hold FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10, REG_ZERO=5'd0 and the slot record type.
REQ-026 One sub-module hazard_slot (async-reset slot register with bubble-load input) SHALL be instantiated three times.

Verification
REQ-027 add $3 (EX) then sub uses $3 (ID->EX next): next cycle fwd_a_sel=01; one cycle later a user of $3 sees 10.
REQ-028 lw $5 in EX, ID uses rt=$5: stall=1 one cycle, bubble in EX; next cycle fwd_b_sel=10, stall=0.
REQ-029 Writes to $0 in MEM and WB, EX reads $0: fwd_a_sel=fwd_b_sel=00, stall=0.
REQ-030 $7 written by MEM and WB instructions, EX reads $7: fwd_a_sel=01.
REQ-031 flush=1 with add $4 in ID: next cycle EX is bubble; EX reads $4 later -> 00 select unless a real writer exists.
REQ-032 rst_n pulsed low during a stall: stall drops immediately, selects 00; with macro, stall_cnt=0 then counts 3 after three further load-use stalls.
